// File: rtl/sgd_dispatch_pkg.sv
// Shared constants and types for the A/B dispatch feeder.
package sgd_dispatch_pkg;

   localparam int unsigned LINE_W        = 512;
   localparam int unsigned NUM_OF_BANKS  = 8;
   localparam int unsigned DIMS_PER_LINE = LINE_W / NUM_OF_BANKS;
   localparam int unsigned B_WORD_W      = 32 * NUM_OF_BANKS;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] dimension;
      logic [31:0] samples;
      logic [31:0] bits;
      logic [31:0] epochs;
   } cfg_t;

endpackage

// File: rtl/sgd_dispatch_b_split.sv
// Splits 512-bit B lines into two 256-bit words and counts words/epochs.
module sgd_dispatch_b_split
   import sgd_dispatch_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_clear,
   input  logic                i_run,
   input  logic [31:0]         i_word_lim,
   input  logic [31:0]         i_epochs,
   input  logic [LINE_W-1:0]   i_b_in_data,
   input  logic                i_b_in_valid,
   output logic                o_b_in_ready,
   output logic [B_WORD_W-1:0] o_b_data,
   output logic                o_b_wr_en,
   input  logic                i_b_almost_full,
   output logic [31:0]         o_epoch_cnt
);

   logic [LINE_W-1:0]   r_hold;
   logic                r_full;
   logic                r_half;
   logic [31:0]         r_word_cnt;
   logic [31:0]         r_epoch_cnt;
   logic [B_WORD_W-1:0] r_data;
   logic                r_wr;
   logic                w_emit;
   logic                w_last;
   logic                w_acc;

   assign w_emit = i_run && r_full && !i_b_almost_full;
   assign w_last = (r_word_cnt == i_word_lim - 32'd1);
   // Refill in the same cycle only while the high half leaves and it does not close the epoch
   assign o_b_in_ready = i_run && (r_epoch_cnt < i_epochs) &&
                         (!r_full || (r_half && w_emit && !w_last));
   assign w_acc = i_b_in_valid && o_b_in_ready;

   assign o_b_data    = r_data;
   assign o_b_wr_en   = r_wr;
   assign o_epoch_cnt = r_epoch_cnt;

   // Holding register, half select, word/epoch counters and registered write strobe
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_hold      <= '0;
         r_full      <= 1'b0;
         r_half      <= 1'b0;
         r_word_cnt  <= '0;
         r_epoch_cnt <= '0;
         r_data      <= '0;
         r_wr        <= 1'b0;
      end else begin
         r_wr <= 1'b0;
         if (i_clear) begin
            r_full      <= 1'b0;
            r_half      <= 1'b0;
            r_word_cnt  <= '0;
            r_epoch_cnt <= '0;
         end else begin
            if (w_emit) begin
               r_data <= r_half ? r_hold[LINE_W-1:B_WORD_W] : r_hold[B_WORD_W-1:0];
               r_wr   <= 1'b1;
               if (w_last) begin
                  // Epoch ends here; an unsent high half is dropped
                  r_word_cnt  <= '0;
                  r_epoch_cnt <= r_epoch_cnt + 32'd1;
                  r_full      <= 1'b0;
                  r_half      <= 1'b0;
               end else begin
                  r_word_cnt <= r_word_cnt + 32'd1;
                  if (r_half) begin
                     r_full <= 1'b0;
                     r_half <= 1'b0;
                  end else begin
                     r_half <= 1'b1;
                  end
               end
            end
            if (w_acc) begin
               r_hold <= i_b_in_data;
               r_full <= 1'b1;
               r_half <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/sgd_axb_dispatch.sv
// Feeds bit-weaved A lines to per-engine FIFOs and split B words to the label FIFO.
module sgd_axb_dispatch
   import sgd_dispatch_pkg::*;
#(
   parameter int unsigned ENGINE_NUM = 2
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_start,
   input  logic [31:0]                         i_dimension,
   input  logic [31:0]                         i_number_of_samples,
   input  logic [31:0]                         i_number_of_bits,
   input  logic [31:0]                         i_number_of_epochs,
   input  logic [LINE_W-1:0]                   i_a_in_data,
   input  logic                                i_a_in_valid,
   output logic                                o_a_in_ready,
   input  logic [LINE_W-1:0]                   i_b_in_data,
   input  logic                                i_b_in_valid,
   output logic                                o_b_in_ready,
   output logic [ENGINE_NUM-1:0][LINE_W-1:0]   o_dispatch_axb_a_data,
   output logic [ENGINE_NUM-1:0]               o_dispatch_axb_a_wr_en,
   input  logic [ENGINE_NUM-1:0]               i_dispatch_axb_a_almost_full,
   output logic [B_WORD_W-1:0]                 o_dispatch_axb_b_data,
   output logic                                o_dispatch_axb_b_wr_en,
   input  logic                                i_dispatch_axb_b_almost_full,
   output logic                                o_done
);

   localparam int unsigned      ENG_W        = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
   localparam int unsigned      DIMS_PER_BLK = DIMS_PER_LINE * ENGINE_NUM;
   localparam logic [ENG_W-1:0] ENG_LAST     = ENG_W'(ENGINE_NUM - 1);

   state_e                            r_state;
   state_e                            w_state_nxt;
   cfg_t                              w_cfg;
   logic [31:0]                       w_blk_lim;
   logic [31:0]                       w_grp_lim;
   logic                              w_cfg_empty;
   logic [31:0]                       r_bits_lim;
   logic [31:0]                       r_blk_lim;
   logic [31:0]                       r_grp_lim;
   logic [31:0]                       r_epochs;
   logic [31:0]                       r_bit_cnt;
   logic [31:0]                       r_blk_cnt;
   logic [31:0]                       r_grp_cnt;
   logic [31:0]                       r_a_epoch;
   logic [ENG_W-1:0]                  r_eng_sel;
   logic [ENGINE_NUM-1:0][LINE_W-1:0] r_a_data;
   logic [ENGINE_NUM-1:0]             r_a_wr;
   logic                              w_run;
   logic                              w_start;
   logic                              w_a_acc;
   logic                              w_bit_wrap;
   logic                              w_eng_wrap;
   logic                              w_blk_wrap;
   logic                              w_grp_wrap;
   logic [31:0]                       w_b_epoch;

   assign w_cfg.dimension = i_dimension;
   assign w_cfg.samples   = i_number_of_samples;
   assign w_cfg.bits      = i_number_of_bits;
   assign w_cfg.epochs    = i_number_of_epochs;

   // Divisions only feed the limit registers loaded on start
   assign w_blk_lim   = w_cfg.dimension / DIMS_PER_BLK;
   assign w_grp_lim   = w_cfg.samples / NUM_OF_BANKS;
   // A config with no work is forced to zero epochs so RUN falls straight through
   assign w_cfg_empty = (w_cfg.epochs == '0) || (w_cfg.bits == '0) ||
                        (w_blk_lim == '0) || (w_grp_lim == '0);

   assign w_run   = (r_state == StRun);
   assign w_start = i_start && (r_state == StIdle);

   assign o_a_in_ready = w_run && !i_dispatch_axb_a_almost_full[r_eng_sel] &&
                         (r_a_epoch < r_epochs);
   assign w_a_acc      = i_a_in_valid && o_a_in_ready;

   assign w_bit_wrap = (r_bit_cnt == r_bits_lim - 32'd1);
   assign w_eng_wrap = w_bit_wrap && (r_eng_sel == ENG_LAST);
   assign w_blk_wrap = w_eng_wrap && (r_blk_cnt == r_blk_lim - 32'd1);
   assign w_grp_wrap = w_blk_wrap && (r_grp_cnt == r_grp_lim - 32'd1);

   assign o_dispatch_axb_a_data  = r_a_data;
   assign o_dispatch_axb_a_wr_en = r_a_wr;
   assign o_done                 = (r_state == StDone);

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= StIdle;
      else          r_state <= w_state_nxt;
   end

   // Next-state: finish once both streams have delivered every epoch
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_nxt = StRun;
         StRun:   if ((r_a_epoch == r_epochs) && (w_b_epoch == r_epochs)) w_state_nxt = StDone;
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // Limit registers loaded once per start
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_bits_lim <= '0;
         r_blk_lim  <= '0;
         r_grp_lim  <= '0;
         r_epochs   <= '0;
      end else if (w_start) begin
         r_bits_lim <= w_cfg.bits;
         r_blk_lim  <= w_blk_lim;
         r_grp_lim  <= w_grp_lim;
         r_epochs   <= w_cfg_empty ? '0 : w_cfg.epochs;
      end
   end

   // A path: capture accepted line for the selected engine and advance the counter nest
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_a_data  <= '0;
         r_a_wr    <= '0;
         r_bit_cnt <= '0;
         r_eng_sel <= '0;
         r_blk_cnt <= '0;
         r_grp_cnt <= '0;
         r_a_epoch <= '0;
      end else begin
         r_a_wr <= '0;
         if (w_start) begin
            r_bit_cnt <= '0;
            r_eng_sel <= '0;
            r_blk_cnt <= '0;
            r_grp_cnt <= '0;
            r_a_epoch <= '0;
         end else if (w_a_acc) begin
            r_a_data[r_eng_sel] <= i_a_in_data;
            r_a_wr[r_eng_sel]   <= 1'b1;
            r_bit_cnt           <= w_bit_wrap ? '0 : r_bit_cnt + 32'd1;
            if (w_bit_wrap) r_eng_sel <= w_eng_wrap ? '0 : r_eng_sel + 1'b1;
            if (w_eng_wrap) r_blk_cnt <= w_blk_wrap ? '0 : r_blk_cnt + 32'd1;
            if (w_blk_wrap) r_grp_cnt <= w_grp_wrap ? '0 : r_grp_cnt + 32'd1;
            if (w_grp_wrap) r_a_epoch <= r_a_epoch + 32'd1;
         end
      end
   end

   sgd_dispatch_b_split u_b_split (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_clear         (w_start),
      .i_run           (w_run),
      .i_word_lim      (r_grp_lim),
      .i_epochs        (r_epochs),
      .i_b_in_data     (i_b_in_data),
      .i_b_in_valid    (i_b_in_valid),
      .o_b_in_ready    (o_b_in_ready),
      .o_b_data        (o_dispatch_axb_b_data),
      .o_b_wr_en       (o_dispatch_axb_b_wr_en),
      .i_b_almost_full (i_dispatch_axb_b_almost_full),
      .o_epoch_cnt     (w_b_epoch)
   );

endmodule

// File: tb/tb_sgd_axb_dispatch.sv
// Bench for sgd_axb_dispatch: config table runs plus a line/word-level reference model.
module tb_sgd_axb_dispatch;
   import sgd_dispatch_pkg::*;

   localparam int unsigned EN = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                        rst_n;
   logic                        start;
   logic [31:0]                 dim;
   logic [31:0]                 smp;
   logic [31:0]                 bits;
   logic [31:0]                 eps;
   logic [LINE_W-1:0]           a_data;
   logic                        a_valid;
   logic                        a_ready;
   logic [LINE_W-1:0]           b_data;
   logic                        b_valid;
   logic                        b_ready;
   logic [EN-1:0][LINE_W-1:0]   da_data;
   logic [EN-1:0]               da_wr;
   logic [EN-1:0]               da_af;
   logic [B_WORD_W-1:0]         db_data;
   logic                        db_wr;
   logic                        db_af;
   logic                        done;

   sgd_axb_dispatch #(.ENGINE_NUM(EN)) dut (
      .i_clk                        (clk),
      .i_rst_n                      (rst_n),
      .i_start                      (start),
      .i_dimension                  (dim),
      .i_number_of_samples          (smp),
      .i_number_of_bits             (bits),
      .i_number_of_epochs           (eps),
      .i_a_in_data                  (a_data),
      .i_a_in_valid                 (a_valid),
      .o_a_in_ready                 (a_ready),
      .i_b_in_data                  (b_data),
      .i_b_in_valid                 (b_valid),
      .o_b_in_ready                 (b_ready),
      .o_dispatch_axb_a_data        (da_data),
      .o_dispatch_axb_a_wr_en       (da_wr),
      .i_dispatch_axb_a_almost_full (da_af),
      .o_dispatch_axb_b_data        (db_data),
      .o_dispatch_axb_b_wr_en       (db_wr),
      .i_dispatch_axb_b_almost_full (db_af),
      .o_done                       (done)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [LINE_W-1:0] act,
                      input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] rnd_line();
      logic [LINE_W-1:0] r;
      for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference model: whole-run totals, line index -> engine, queue of pending B words
   typedef struct {
      logic [B_WORD_W-1:0] w;
      bit                  last;
   } bword_t;

   bword_t              hq[$];
   bit                  m_run = 1'b0;
   longint              a_tot, a_cnt, lpe, m_bits, w_per_ep;
   longint              b_wtot, b_wcnt, b_ltot, b_lcnt, b_pos;
   logic [EN-1:0]       p_awr = '0;
   logic [LINE_W-1:0]   p_adata = '0;
   bit                  p_bwr = 1'b0;
   logic [B_WORD_W-1:0] p_bdata = '0;
   bit                  p_done = 1'b0;
   int                  done_cnt = 0;
   int                  a_wr_cnt = 0;
   int                  b_wr_cnt = 0;
   int                  eng_cnt[EN];

   function automatic int eng_of(longint k);
      return int'(((k % lpe) / m_bits) % EN);
   endfunction

   task automatic push_half(input logic [B_WORD_W-1:0] w, output bit last);
      bword_t bw;
      b_pos++;
      bw.w    = w;
      bw.last = (b_pos == w_per_ep);
      if (bw.last) b_pos = 0;
      hq.push_back(bw);
      last = bw.last;
   endtask

   // Checks outputs of the edge just taken, then predicts the next edge
   always @(negedge clk) begin : monitor
      int     e;
      logic   exp_ar;
      logic   exp_br;
      bit     emit;
      bit     lst;
      bword_t bw;
      chk("a_wr_en", da_wr, p_awr);
      for (int i = 0; i < EN; i++) if (p_awr[i]) chk("a_data", da_data[i], p_adata);
      chk("b_wr_en", db_wr, p_bwr);
      if (p_bwr) chk("b_data", db_data, p_bdata);
      chk("done", done, p_done);
      for (int i = 0; i < EN; i++) if (da_wr[i]) begin a_wr_cnt++; eng_cnt[i]++; end
      if (db_wr) b_wr_cnt++;
      if (done) done_cnt++;

      e      = (m_run && a_cnt < a_tot) ? eng_of(a_cnt) : 0;
      exp_ar = m_run && !da_af[e] && (a_cnt < a_tot);
      emit   = m_run && (hq.size() > 0) && !db_af;
      exp_br = m_run && (b_lcnt < b_ltot) &&
               ((hq.size() == 0) || (hq.size() == 1 && emit && !hq[0].last));
      chk("a_in_ready", a_ready, exp_ar);
      chk("b_in_ready", b_ready, exp_br);

      p_awr  = '0;
      p_bwr  = 1'b0;
      p_done = 1'b0;
      if (!rst_n) begin
         m_run = 1'b0;
         hq.delete();
      end else if (m_run && a_cnt == a_tot && b_wcnt == b_wtot) begin
         p_done = 1'b1;
         m_run  = 1'b0;
      end else if (m_run) begin
         if (a_valid && exp_ar) begin
            p_awr[e] = 1'b1;
            p_adata  = a_data;
            a_cnt++;
         end
         if (emit) begin
            bw      = hq.pop_front();
            p_bwr   = 1'b1;
            p_bdata = bw.w;
            b_wcnt++;
         end
         if (b_valid && exp_br) begin
            push_half(b_data[B_WORD_W-1:0], lst);
            if (!lst) push_half(b_data[LINE_W-1:B_WORD_W], lst);
            b_lcnt++;
         end
      end else if (start) begin
         m_run    = 1'b1;
         m_bits   = bits;
         w_per_ep = smp / NUM_OF_BANKS;
         if (eps == 0 || smp == 0) begin
            lpe = 1; a_tot = 0; b_wtot = 0; b_ltot = 0;
         end else begin
            lpe    = longint'(bits) * (dim / DIMS_PER_LINE) * w_per_ep;
            a_tot  = lpe * eps;
            b_wtot = w_per_ep * eps;
            b_ltot = ((w_per_ep + 1) / 2) * eps;
         end
         a_cnt = 0; b_wcnt = 0; b_lcnt = 0; b_pos = 0;
         hq.delete();
      end
   end

   // mode: 0 random, 1 hold engine1 almost_full, 2 toggle b almost_full, 3 empty config
   typedef struct {
      int unsigned bits;
      int unsigned dim;
      int unsigned smp;
      int unsigned eps;
      int          exp_a;
      int          exp_b;
      int          mode;
   } vec_t;

   vec_t tbl[9];

   task automatic drive(input int mode, input int cyc);
      a_data  = rnd_line();
      b_data  = rnd_line();
      a_valid = ($urandom % 4) != 0;
      b_valid = ($urandom % 4) != 0;
      da_af   = {($urandom % 6) == 0, ($urandom % 6) == 0};
      db_af   = ($urandom % 4) == 0;
      if (mode == 1) begin
         a_valid = 1'b1;
         da_af   = (cyc >= 3 && cyc < 23) ? 2'b10 : 2'b00;
      end
      if (mode == 2) begin
         b_valid = 1'b1;
         db_af   = cyc[0];
      end
   endtask

   task automatic idle_inputs();
      a_valid = 1'b0; b_valid = 1'b0; da_af = '0; db_af = 1'b0; start = 1'b0;
   endtask

   task automatic run(input vec_t v);
      int d0;
      int cyc;
      d0 = done_cnt; a_wr_cnt = 0; b_wr_cnt = 0;
      for (int i = 0; i < EN; i++) eng_cnt[i] = 0;
      @(posedge clk); #1;
      bits = v.bits; dim = v.dim; smp = v.smp; eps = v.eps; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (done_cnt == d0 && cyc < 4000) begin
         drive(v.mode, cyc);
         @(posedge clk); #1;
         cyc++;
      end
      idle_inputs();
      if (v.mode == 3) chk("empty config done latency ok", cyc <= 3, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("done pulse count", done_cnt - d0, 1);
      chk("a lines written", a_wr_cnt, v.exp_a);
      chk("engine0 lines", eng_cnt[0], v.exp_a / 2);
      chk("b words written", b_wr_cnt, v.exp_b);
   endtask

   initial begin
      vec_t restart;
      rst_n = 1'b0; start = 1'b0; dim = '0; smp = '0; bits = '0; eps = '0;
      a_data = '0; b_data = '0;
      idle_inputs();
      for (int i = 0; i < EN; i++) eng_cnt[i] = 0;
      //          bits  dim  smp eps exp_a exp_b mode
      tbl[0] = '{ 2,   256, 16, 1, 16,   2,    0};
      tbl[1] = '{ 2,   256, 16, 1, 16,   2,    1};
      tbl[2] = '{ 1,   128, 24, 2, 12,   6,    0};
      tbl[3] = '{ 1,   128, 24, 2, 12,   6,    2};
      tbl[4] = '{ 2,   128, 16, 0, 0,    0,    3};
      tbl[5] = '{ 2,   128, 0,  3, 0,    0,    3};
      tbl[6] = '{ 3,   256, 8,  2, 24,   2,    0};
      tbl[7] = '{ 1,   384, 32, 1, 24,   4,    0};
      tbl[8] = '{ 32,  128, 8,  1, 64,   1,    2};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset a_data0", da_data[0], '0);
      chk("reset a_data1", da_data[1], '0);
      chk("reset b_data", db_data, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run(tbl[i]);

      // Reset in the middle of a two-epoch run, then restart with a smaller config
      @(posedge clk); #1;
      bits = 2; dim = 256; smp = 16; eps = 2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         drive(0, c);
         @(posedge clk); #1;
      end
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid reset a_data0", da_data[0], '0);
      chk("mid reset a_data1", da_data[1], '0);
      chk("mid reset b_data", db_data, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      restart = '{1, 128, 16, 1, 4, 2, 0};
      run(restart);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
